rr_burst_arbiter: RTL
=====================

# rr_burst_arbiter

Round-robin arbiter that shares one run/last-sequenced resource among N requesters. A three-state machine (IDLE, RUN, LAST) grants one requester at a time for a burst. Combinational transition pulses mark grant start and burst end. Registered state outputs drive the grant vector, so the resource sees a glitch-free, one-hot enable. The burst is forcibly ended after MAX_BURST cycles to bound latency for the other requesters.

## Interface
- N, default 4: number of requesters; legal range 2..16.
- MAX_BURST, default 16: maximum consecutive grant cycles per burst; legal range 1..255.

- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  N  level request per requester; held high while the requester wants the resource.
- gnt  output  N  registered one-hot grant; all zero outside RUN.
- gnt_id  output  $clog2(N)  registered index of the current owner; 0 when gnt is zero.
- busy  output  1  registered; high in RUN and LAST.
- start  output  1  combinational pulse in the IDLE cycle where a winner is chosen.
- done  output  1  combinational pulse in the RUN cycle where the burst ends.
- preempt  output  1  combinational; high with done when the burst ended on MAX_BURST while req[owner] was still high.

## Operation
- State registers: `state`, `owner`, `ptr` (round-robin base), `cnt` (width $clog2(MAX_BURST+1)).
- IDLE:
  - If any req is high, pick the first set bit scanning ptr, ptr+1, … N-1, 0, … ptr-1.
  - Then set owner to the winner, nextstate to RUN, and assert start.
  - If no req is high, stay in IDLE.
- RUN:
  - cnt counts RUN cycles, starting at 1 in the first RUN cycle.
  - If !req[owner] or cnt==MAX_BURST: nextstate is LAST, done=1, ptr <= owner+1 (wraps N-1 to 0), and preempt = req[owner].
  - Otherwise stay in RUN.
  - req of non-owners is ignored.
- LAST: single turnaround cycle, then unconditionally IDLE. req is ignored.
- Registered outputs are computed from nextstate:
  - gnt[owner], gnt_id and busy update on the same edge the state changes.
  - gnt and gnt_id are zero unless nextstate is RUN.
- Reset values:
  - state = IDLE; ptr, owner, cnt = 0.
  - gnt = 0, gnt_id = 0, busy = 0.
  - start, done and preempt are forced to 0 while rst is high.
- Reset in mid-burst: the next cycle gnt=0, busy=0, ptr=0. No done pulse is issued.
- Simultaneous requests: exactly one winner per IDLE cycle, chosen by ptr order. No two gnt bits are ever high together.

## Timing
- Request to start: req rises at cycle t while the arbiter is in IDLE → start in cycle t, gnt high from t+1.
- Release: the owner drops req in RUN cycle k → done in that cycle. gnt stays high in cycle k and clears at k+1 (LAST). The arbiter is in IDLE at k+2, so the earliest next gnt is k+3.
- Burst length: gnt is high for min(k, MAX_BURST) cycles.
- Grant spacing: at least 2 idle gnt cycles between consecutive bursts.
- Fairness: with all N requests held high, each requester gets a burst within N bursts.
- Worst-case wait is (N-1)·(MAX_BURST+2)+1 cycles.

## Structure
- Shared package holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, LAST=2'd2;
  - the state width;
  - a function returning N's index width.
- One sub-module, `rr_pick`: purely combinational. Inputs req and ptr; outputs valid and idx. It is reusable by other arbiters.
- The top level contains the transition always block (nextstate, start, done, preempt), the state register, and the sequential output block.

## Test plan
- Single requester: N=4, MAX_BURST=16. req[2] high for 5 cycles then low → start once, gnt=4'b0100 for 5 cycles, gnt_id=2, done on the 5th, busy for 6 cycles.
- Contention order: req=4'b1111 held high, MAX_BURST=3 → grants go to 0,1,2,3,0. Each gnt lasts 3 cycles with preempt=1. There are 2 gnt-zero cycles between bursts.
- Round-robin pointer: burst by 1 finishes, then req=4'b0011 → winner is 0 only after requester 1 wraps past. With ptr=2 and req=4'b0011, the winner is 0.
- Drop in the first cycle: owner drops req in the first RUN cycle → gnt high 1 cycle, done=1, preempt=0, and the next grant no earlier than 3 cycles later.
- Mid-burst reset: rst pulsed in the 3rd RUN cycle → next cycle gnt=0, busy=0, no done. The first post-reset grant with req=4'b1111 goes to 0.
- Invariant checks run on every cycle: gnt is one-hot or zero, start is never high outside IDLE, and done is never high outside RUN.

Source files
------------

// File: rtl/rr_burst_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_burst_arbiter_pkg
// Description : Shared state encoding and sizing helper for the burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_burst_arbiter_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    // Index width for n requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first set req bit at or
//               after ptr, wrapping at N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_burst_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] c_N_EXT = (IDX_W+1)'(N);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotate so that bit 0 of w_rot corresponds to requester ptr.
    assign w_rot = N'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign valid = |req;
    assign idx   = (w_sum >= c_N_EXT) ? IDX_W'(w_sum - c_N_EXT) : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_burst_arbiter
// Description : Round-robin burst arbiter (IDLE/RUN/LAST) with registered
//               one-hot grant and MAX_BURST preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter int   N         = 4,
    parameter int   MAX_BURST = 16,
    localparam int  IDX_W     = idx_width(N),
    localparam int  CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             busy,
    output logic             start,
    output logic             done,
    output logic             preempt
);

    state_t           r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_next_state;
    logic [IDX_W-1:0] w_next_owner;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_valid;
    logic [IDX_W-1:0] w_win;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_win)
    );

    assign w_ptr_next = (r_owner == IDX_W'(N - 1)) ? '0 : r_owner + IDX_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        start        = 1'b0;
        done         = 1'b0;
        preempt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next_state = RUN;
                    w_next_owner = w_win;
                    start        = 1'b1;
                end
            end
            RUN: begin
                if (!req[r_owner] || (r_cnt == CNT_W'(MAX_BURST))) begin
                    w_next_state = LAST;
                    done         = 1'b1;
                    preempt      = req[r_owner];
                end
            end
            LAST:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        // Pulses are suppressed during reset so a reset mid-burst never looks like a release.
        if (rst) begin
            start   = 1'b0;
            done    = 1'b0;
            preempt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            if ((r_state == RUN) && (w_next_state == LAST)) begin
                r_ptr <= w_ptr_next;
            end
            if (w_next_state == RUN) begin
                r_cnt <= (r_state == RUN) ? r_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Outputs are driven from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            busy   <= (w_next_state != IDLE);
            gnt    <= (w_next_state == RUN) ? (N'(1) << w_next_owner) : '0;
            gnt_id <= (w_next_state == RUN) ? w_next_owner : '0;
        end
    end

endmodule
`default_nettype wire
